// File: rtl/wb_stage_if.sv
// Bus bundle between the memory-access stage, the writeback stage and the
// register file / IO read port.
interface wb_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_wb_sel;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_addr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_alu;
  logic [4:0]      in_rd;
  logic            in_rf_we;
  logic [XLEN-1:0] dmem_dout;
  logic [XLEN-1:0] bios_dout;
  logic            io_req;
  logic [XLEN-1:0] io_rdata;
  logic            io_valid;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            io_timeout_err;

  modport slave (
    input  in_valid, in_wb_sel, in_funct3, in_addr, in_pc, in_alu, in_rd,
           in_rf_we, dmem_dout, bios_dout, io_rdata, io_valid,
    output in_ready, io_req, rf_we, rf_rd, rf_wdata, io_timeout_err
  );

  modport master (
    output in_valid, in_wb_sel, in_funct3, in_addr, in_pc, in_alu, in_rd,
           in_rf_we, dmem_dout, bios_dout, io_rdata, io_valid,
    input  in_ready, io_req, rf_we, rf_rd, rf_wdata, io_timeout_err
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: source select, load extraction and a stalling IO read path
// with timeout, registered into the register file write port.
module wb_stage #(
  parameter int unsigned XLEN       = 32,
  parameter logic [3:0]  BIOS_NIB   = 4'b0100,
  parameter logic [3:0]  IO_NIB     = 4'b1000,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(IO_TIMEOUT + 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] IO_WAIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            io_req_q, io_req_d;
  logic            err_q, err_d;
  logic [4:0]      io_rd_q, io_rd_d;
  logic            io_we_q, io_we_d;
  logic [2:0]      io_funct3_q, io_funct3_d;
  logic [1:0]      io_off_q, io_off_d;

  logic [3:0]      nib;
  logic            accept;
  logic            is_io;
  logic [XLEN-1:0] load_word;
  logic [XLEN-1:0] result;

  // Byte/half/word select with sign or zero extension; unknown funct3 acts as LW.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                              input logic [2:0]      f3,
                                              input logic [1:0]      off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{(XLEN-8){b[7]}}, b};
      3'b001:  extract = {{(XLEN-16){h[15]}}, h};
      3'b100:  extract = {{(XLEN-8){1'b0}}, b};
      3'b101:  extract = {{(XLEN-16){1'b0}}, h};
      default: extract = word;
    endcase
  endfunction

  assign nib    = bus.in_addr[XLEN-1 -: 4];
  assign accept = bus.in_valid && (state_q == IDLE);
  assign is_io  = (bus.in_wb_sel == 2'd1) && (nib == IO_NIB);

  // Non-IO writeback value for the instruction currently offered.
  always_comb begin
    load_word = (nib == BIOS_NIB) ? bus.bios_dout : bus.dmem_dout;
    case (bus.in_wb_sel)
      2'd1:    result = extract(load_word, bus.in_funct3, bus.in_addr[1:0]);
      2'd2:    result = bus.in_pc + XLEN'(4);
      default: result = bus.in_alu;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rf_we_d     = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_wdata_d  = rf_wdata_q;
    io_req_d    = 1'b0;
    err_d       = err_q;
    io_rd_d     = io_rd_q;
    io_we_d     = io_we_q;
    io_funct3_d = io_funct3_q;
    io_off_d    = io_off_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_io) begin
            state_d     = IO_WAIT;
            cnt_d       = '0;
            io_req_d    = 1'b1;
            io_rd_d     = bus.in_rd;
            io_we_d     = bus.in_rf_we;
            io_funct3_d = bus.in_funct3;
            io_off_d    = bus.in_addr[1:0];
          end else begin
            rf_we_d    = bus.in_rf_we && (bus.in_rd != 5'd0);
            rf_rd_d    = bus.in_rd;
            rf_wdata_d = result;
          end
        end
      end
      IO_WAIT: begin
        if (bus.io_valid) begin
          state_d    = IDLE;
          rf_we_d    = io_we_q && (io_rd_q != 5'd0);
          rf_rd_d    = io_rd_q;
          rf_wdata_d = extract(bus.io_rdata, io_funct3_q, io_off_q);
        end else if (cnt_q == CNT_W'(IO_TIMEOUT - 1)) begin
          // Timed out: retire the load with zero so the pipeline keeps moving.
          state_d    = IDLE;
          rf_we_d    = io_we_q && (io_rd_q != 5'd0);
          rf_rd_d    = io_rd_q;
          rf_wdata_d = '0;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_wdata_q  <= '0;
      io_req_q    <= 1'b0;
      err_q       <= 1'b0;
      io_rd_q     <= '0;
      io_we_q     <= 1'b0;
      io_funct3_q <= '0;
      io_off_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_wdata_q  <= rf_wdata_d;
      io_req_q    <= io_req_d;
      err_q       <= err_d;
      io_rd_q     <= io_rd_d;
      io_we_q     <= io_we_d;
      io_funct3_q <= io_funct3_d;
      io_off_q    <= io_off_d;
    end
  end

  assign bus.in_ready       = (state_q == IDLE);
  assign bus.io_req         = io_req_q;
  assign bus.rf_we          = rf_we_q;
  assign bus.rf_rd          = rf_rd_q;
  assign bus.rf_wdata       = rf_wdata_q;
  assign bus.io_timeout_err = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (IO_TIMEOUT shortened to 4).
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(32)) bus ();

  wb_stage #(
    .XLEN      (32),
    .BIOS_NIB  (4'b0100),
    .IO_NIB    (4'b1000),
    .IO_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rd,
                       input logic we);
    bus.in_valid  = 1'b1;
    bus.in_wb_sel = sel;
    bus.in_funct3 = f3;
    bus.in_addr   = addr;
    bus.in_pc     = pc;
    bus.in_alu    = alu;
    bus.in_rd     = rd;
    bus.in_rf_we  = we;
  endtask

  task automatic wb(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
    check({tag, "_we"}, 32'(bus.rf_we), 32'(we));
    check({tag, "_rd"}, 32'(bus.rf_rd), 32'(rd));
    check({tag, "_wdata"}, bus.rf_wdata, data);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_wb_sel = 2'd0;
    bus.in_funct3 = 3'b010;
    bus.in_addr   = '0;
    bus.in_pc     = '0;
    bus.in_alu    = '0;
    bus.in_rd     = '0;
    bus.in_rf_we  = 1'b0;
    bus.dmem_dout = 32'hDEADBEEF;
    bus.bios_dout = 32'h80FF0000;
    bus.io_rdata  = '0;
    bus.io_valid  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    wb("reset", 1'b0, 5'd0, 32'h0);
    check("reset_io_req", 32'(bus.io_req), 32'h0);
    check("reset_err", 32'(bus.io_timeout_err), 32'h0);
    check("reset_ready", 32'(bus.in_ready), 32'h1);

    // DMEM word load, then one bubble.
    offer(2'd1, 3'b010, 32'h10000004, 32'h0, 32'h0, 5'd5, 1'b1);
    cyc();
    wb("lw_dmem", 1'b1, 5'd5, 32'hDEADBEEF);
    bus.in_valid = 1'b0;
    cyc();
    wb("lw_bubble", 1'b0, 5'd5, 32'hDEADBEEF);

    // Back-to-back BIOS sub-word loads.
    offer(2'd1, 3'b000, 32'h40000003, 32'h0, 32'h0, 5'd6, 1'b1);
    cyc();
    wb("lb_bios", 1'b1, 5'd6, 32'hFFFFFF80);
    offer(2'd1, 3'b100, 32'h40000003, 32'h0, 32'h0, 5'd7, 1'b1);
    cyc();
    wb("lbu_bios", 1'b1, 5'd7, 32'h00000080);
    offer(2'd1, 3'b001, 32'h40000002, 32'h0, 32'h0, 5'd8, 1'b1);
    cyc();
    wb("lh_bios", 1'b1, 5'd8, 32'hFFFF80FF);
    offer(2'd1, 3'b101, 32'h10000000, 32'h0, 32'h0, 5'd9, 1'b1);
    cyc();
    wb("lhu_dmem", 1'b1, 5'd9, 32'h0000BEEF);

    // PC+4, rd=0 suppression, wraparound, ALU sources.
    offer(2'd2, 3'b010, 32'h0, 32'h00000100, 32'h0, 5'd1, 1'b1);
    cyc();
    wb("pc4", 1'b1, 5'd1, 32'h00000104);
    offer(2'd2, 3'b010, 32'h0, 32'h00000200, 32'h0, 5'd0, 1'b1);
    cyc();
    check("pc4_rd0_we", 32'(bus.rf_we), 32'h0);
    offer(2'd2, 3'b010, 32'h0, 32'hFFFFFFFC, 32'h0, 5'd2, 1'b1);
    cyc();
    wb("pc4_wrap", 1'b1, 5'd2, 32'h00000000);
    offer(2'd0, 3'b010, 32'h80000000, 32'h0, 32'h12345678, 5'd3, 1'b1);
    cyc();
    wb("alu0", 1'b1, 5'd3, 32'h12345678);
    offer(2'd3, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 5'd4, 1'b0);
    cyc();
    wb("alu3_nowe", 1'b0, 5'd4, 32'hCAFEF00D);

    // io_valid while idle is ignored.
    bus.in_valid = 1'b0;
    bus.io_valid = 1'b1;
    bus.io_rdata = 32'h99;
    cyc();
    check("io_idle_we", 32'(bus.rf_we), 32'h0);
    bus.io_valid = 1'b0;

    // IO word load completing at t+3.
    offer(2'd1, 3'b010, 32'h80000004, 32'h0, 32'h0, 5'd10, 1'b1);
    check("io_t_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    bus.in_valid = 1'b0;
    check("io_t1_req", 32'(bus.io_req), 32'h1);
    check("io_t1_ready", 32'(bus.in_ready), 32'h0);
    check("io_t1_we", 32'(bus.rf_we), 32'h0);
    cyc();
    check("io_t2_req", 32'(bus.io_req), 32'h0);
    check("io_t2_ready", 32'(bus.in_ready), 32'h0);
    cyc();
    check("io_t3_ready", 32'(bus.in_ready), 32'h0);
    bus.io_valid = 1'b1;
    bus.io_rdata = 32'h41;
    cyc();
    bus.io_valid = 1'b0;
    wb("io_t4", 1'b1, 5'd10, 32'h00000041);
    check("io_t4_ready", 32'(bus.in_ready), 32'h1);
    offer(2'd0, 3'b010, 32'h0, 32'h0, 32'h00000055, 5'd11, 1'b1);
    cyc();
    wb("io_next", 1'b1, 5'd11, 32'h00000055);

    // IO signed byte load from lane 1.
    offer(2'd1, 3'b000, 32'h80000001, 32'h0, 32'h0, 5'd12, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    bus.io_valid = 1'b1;
    bus.io_rdata = 32'h00008000;
    cyc();
    bus.io_valid = 1'b0;
    wb("io_lb", 1'b1, 5'd12, 32'hFFFFFF80);

    // Timeout; io_valid in the accept cycle must not count.
    offer(2'd1, 3'b010, 32'h80000000, 32'h0, 32'h0, 5'd13, 1'b1);
    bus.io_valid = 1'b1;
    bus.io_rdata = 32'h77;
    cyc();
    bus.in_valid = 1'b0;
    bus.io_valid = 1'b0;
    check("to_t1_we", 32'(bus.rf_we), 32'h0);
    cyc();
    cyc();
    cyc();
    check("to_t4_we", 32'(bus.rf_we), 32'h0);
    check("to_t4_ready", 32'(bus.in_ready), 32'h0);
    check("to_t4_err", 32'(bus.io_timeout_err), 32'h0);
    cyc();
    wb("to_t5", 1'b1, 5'd13, 32'h00000000);
    check("to_t5_err", 32'(bus.io_timeout_err), 32'h1);
    check("to_t5_ready", 32'(bus.in_ready), 32'h1);
    for (int i = 0; i < 10; i++) begin
      offer(2'd0, 3'b010, 32'h0, 32'h0, 32'(i + 100), 5'(i + 1), 1'b1);
      cyc();
    end
    bus.in_valid = 1'b0;
    wb("sticky_last", 1'b1, 5'd10, 32'd109);
    check("sticky_err", 32'(bus.io_timeout_err), 32'h1);

    // Reset during IO wait clears everything; later io_valid ignored.
    offer(2'd1, 3'b010, 32'h80000008, 32'h0, 32'h0, 5'd14, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_t3_ready", 32'(bus.in_ready), 32'h1);
    check("rst_t3_err", 32'(bus.io_timeout_err), 32'h0);
    check("rst_t3_we", 32'(bus.rf_we), 32'h0);
    bus.io_valid = 1'b1;
    bus.io_rdata = 32'h1234;
    cyc();
    bus.io_valid = 1'b0;
    cyc();
    wb("rst_t5", 1'b0, 5'd0, 32'h0);
    check("rst_t5_ready", 32'(bus.in_ready), 32'h1);
    check("rst_t5_err", 32'(bus.io_timeout_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
